// File: rtl/nn_pkg.sv
// ============================================================================
// nn_pkg: shared widths, saturation limits and FSM encoding.  Rev 1.0
// ============================================================================
`default_nettype none

package nn_pkg;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 40;
  localparam int AW    = 4;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;
endpackage

`default_nettype wire

// File: rtl/neuron_mac_if.sv
// ============================================================================
// neuron_mac_if: operand-pair input stream and tagged result stream.  Rev 1.0
// ============================================================================
`default_nettype none

interface neuron_mac_if #(
  parameter int DW = nn_pkg::DW,
  parameter int AW = nn_pkg::AW
) ();
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] in_weight;
  logic          in_first;
  logic          in_last;
  logic [AW-1:0] in_out_addr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_sat;
  logic          seq_err;

  modport slave (
    input  in_valid, in_data, in_weight, in_first, in_last, in_out_addr, out_ready,
    output in_ready, out_valid, out_data, out_addr, out_sat, seq_err
  );

  modport master (
    output in_valid, in_data, in_weight, in_first, in_last, in_out_addr, out_ready,
    input  in_ready, out_valid, out_data, out_addr, out_sat, seq_err
  );
endinterface

`default_nettype wire

// File: rtl/mac_requant.sv
// ============================================================================
// mac_requant: round-half-up requantize, saturate to DW, optional ReLU.  Rev 1.0
// ============================================================================
`default_nettype none

module mac_requant #(
  parameter int DW    = nn_pkg::DW,
  parameter int FRAC  = nn_pkg::FRAC,
  parameter int ACC_W = nn_pkg::ACC_W,
  parameter int RELU  = 1
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [DW-1:0]    data,
  output logic                    sat
);
  import nn_pkg::*;

  localparam logic signed [ACC_W-1:0] HALF  = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC-1);
  localparam logic signed [ACC_W-1:0] R_MAX = {{(ACC_W-DW){1'b0}}, SAT_MAX};
  localparam logic signed [ACC_W-1:0] R_MIN = {{(ACC_W-DW){1'b1}}, SAT_MIN};

  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;
  logic        [DW-1:0]    clamped;

  assign rounded = acc + HALF;
  assign shifted = rounded >>> FRAC;

  always_comb begin
    sat     = 1'b0;
    clamped = shifted[DW-1:0];
    if (shifted > R_MAX) begin
      clamped = SAT_MAX;
      sat     = 1'b1;
    end else if (shifted < R_MIN) begin
      clamped = SAT_MIN;
      sat     = 1'b1;
    end
    // ReLU acts after the clamp, so sat still reports a negative saturation
    data = ((RELU != 0) && clamped[DW-1]) ? '0 : clamped;
  end
endmodule

`default_nettype wire

// File: rtl/neuron_mac.sv
// ============================================================================
// neuron_mac: per-neuron multiply-accumulate, requantize and activate.  Rev 1.0
// ============================================================================
`default_nettype none

module neuron_mac #(
  parameter int DW    = nn_pkg::DW,
  parameter int FRAC  = nn_pkg::FRAC,
  parameter int ACC_W = nn_pkg::ACC_W,
  parameter int AW    = nn_pkg::AW,
  parameter int RELU  = 1
) (
  input  logic         clk,
  input  logic         rst,
  neuron_mac_if.slave  bus
);
  import nn_pkg::*;

  state_t state, state_nxt;
  logic   alive, stall, ready, accept, eff_first, err_set, err;

  logic signed [2*DW-1:0] s1_prod;
  logic                   s1_valid, s1_first, s1_last;
  logic        [AW-1:0]   s1_addr;
  logic signed [ACC_W-1:0] acc, prod_ext;
  logic                   s2_done;
  logic        [AW-1:0]   s2_addr;
  logic                   res_valid, res_sat, rq_sat;
  logic        [DW-1:0]   res_data, rq_data;
  logic        [AW-1:0]   res_addr;

  // in_ready is withheld for the first cycle after reset releases
  assign stall  = res_valid && !bus.out_ready;
  assign ready  = alive && !stall;
  assign accept = bus.in_valid && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      alive <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
      if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    eff_first = bus.in_first || (state == IDLE);
    err_set   = 1'b0;
    if (accept) begin
      err_set   = (state == IDLE) ? !bus.in_first : bus.in_first;
      state_nxt = bus.in_last ? IDLE : ACC;
    end
  end

  assign prod_ext = {{(ACC_W-2*DW){s1_prod[2*DW-1]}}, s1_prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_prod   <= '0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_addr   <= '0;
      acc       <= '0;
      s2_done   <= 1'b0;
      s2_addr   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_sat   <= 1'b0;
      res_addr  <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_prod  <= $signed(bus.in_data) * $signed(bus.in_weight);
        s1_first <= eff_first;
        s1_last  <= bus.in_last;
        s1_addr  <= bus.in_out_addr;
      end
      s2_done <= s1_valid && s1_last;
      if (s1_valid) begin
        acc     <= s1_first ? prod_ext : acc + prod_ext;
        s2_addr <= s1_addr;
      end
      res_valid <= s2_done;
      if (s2_done) begin
        res_data <= rq_data;
        res_sat  <= rq_sat;
        res_addr <= s2_addr;
      end
    end
  end

  mac_requant #(
    .DW    (DW),
    .FRAC  (FRAC),
    .ACC_W (ACC_W),
    .RELU  (RELU)
  ) u_requant (
    .acc  (acc),
    .data (rq_data),
    .sat  (rq_sat)
  );

  assign bus.in_ready  = ready;
  assign bus.out_valid = res_valid;
  assign bus.out_data  = res_data;
  assign bus.out_addr  = res_addr;
  assign bus.out_sat   = res_sat;
  assign bus.seq_err   = err;
endmodule

`default_nettype wire

// File: tb/tb_neuron_mac.sv
// ============================================================================
// tb_neuron_mac: directed self-checking bench for neuron_mac (ReLU and linear).  Rev 1.0
// ============================================================================
`default_nettype none

module tb_neuron_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  logic        got, s0, s1;
  logic [15:0] d0, d1;
  logic [3:0]  a0;

  always #5 clk = ~clk;

  neuron_mac_if #(.DW(16), .AW(4)) bus0 ();
  neuron_mac_if #(.DW(16), .AW(4)) bus1 ();

  // the linear instance mirrors the stimulus of the ReLU instance
  assign bus1.in_valid    = bus0.in_valid;
  assign bus1.in_data     = bus0.in_data;
  assign bus1.in_weight   = bus0.in_weight;
  assign bus1.in_first    = bus0.in_first;
  assign bus1.in_last     = bus0.in_last;
  assign bus1.in_out_addr = bus0.in_out_addr;
  assign bus1.out_ready   = bus0.out_ready;

  neuron_mac #(.RELU(1)) dut     (.clk(clk), .rst(rst), .bus(bus0));
  neuron_mac #(.RELU(0)) dut_lin (.clk(clk), .rst(rst), .bus(bus1));

  task automatic beat(input logic [15:0] d, input logic [15:0] w,
                      input logic f, input logic l, input logic [3:0] a);
    @(negedge clk);
    bus0.in_valid    = 1'b1;
    bus0.in_data     = d;
    bus0.in_weight   = w;
    bus0.in_first    = f;
    bus0.in_last     = l;
    bus0.in_out_addr = a;
    for (int i = 0; i < 50 && !bus0.in_ready; i++) @(negedge clk);
    if (!bus0.in_ready) begin
      total++;
      $display("FAIL beat_accept_timeout: in_ready=%b required 1", bus0.in_ready);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus0.in_valid = 1'b0;
  endtask

  task automatic wait_result();
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.out_valid) begin
        got = 1'b1;
        d0 = bus0.out_data;  s0 = bus0.out_sat;  a0 = bus0.out_addr;
        d1 = bus1.out_data;  s1 = bus1.out_sat;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus0.in_valid = 0; bus0.in_data = 0; bus0.in_weight = 0;
    bus0.in_first = 0; bus0.in_last = 0; bus0.in_out_addr = 0;
    bus0.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus0.out_valid, bus0.out_data, bus0.out_addr, bus0.out_sat, bus0.seq_err, bus0.in_ready} !== '0)
      $display("FAIL reset_outputs: v=%b d=%h a=%h s=%b e=%b r=%b required all 0", bus0.out_valid,
               bus0.out_data, bus0.out_addr, bus0.out_sat, bus0.seq_err, bus0.in_ready);
    else passed++;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus0.in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b required 1", bus0.in_ready);
    else passed++;
  endtask

  task automatic test_one_beat();
    beat(16'h0100, 16'h0200, 1, 1, 4'd3);
    #1;
    total++;
    if (bus0.out_valid !== 1'b0) $display("FAIL lat_n0: out_valid=%b required 0", bus0.out_valid);
    else passed++;
    idle();
    @(posedge clk); #1;
    total++;
    if (bus0.out_valid !== 1'b0) $display("FAIL lat_n1: out_valid=%b required 0", bus0.out_valid);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({bus0.out_valid, bus0.out_data, bus0.out_addr, bus0.out_sat} !== {1'b1, 16'h0200, 4'd3, 1'b0})
      $display("FAIL one_beat: v=%b d=%h a=%0d s=%b required v=1 d=0200 a=3 s=0",
               bus0.out_valid, bus0.out_data, bus0.out_addr, bus0.out_sat);
    else passed++;
  endtask

  task automatic test_long();
    logic early = 1'b0;
    for (int i = 0; i < 12; i++) begin
      beat(16'h0080, 16'h0100, i == 0, i == 11, 4'd4);
      #1 if (bus0.out_valid) early = 1'b1;
    end
    total++;
    if (early !== 1'b0) $display("FAIL long_early: early out_valid=%b required 0", early);
    else passed++;
    idle();
    wait_result();
    total++;
    if ({got, d0, a0} !== {1'b1, 16'h0600, 4'd4})
      $display("FAIL long_result: got=%b d=%h a=%0d required got=1 d=0600 a=4", got, d0, a0);
    else passed++;
  endtask

  task automatic test_relu();
    beat(16'h0100, 16'hFF00, 1, 1, 4'd2);
    idle();
    wait_result();
    total++;
    if ({got, d0, s0} !== {1'b1, 16'h0000, 1'b0})
      $display("FAIL relu_on: got=%b d=%h s=%b required got=1 d=0000 s=0", got, d0, s0);
    else passed++;
    total++;
    if ({d1, s1} !== {16'hFF00, 1'b0})
      $display("FAIL relu_off: d=%h s=%b required d=ff00 s=0", d1, s1);
    else passed++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) beat(16'h7F00, 16'h0200, i == 0, i == 3, 4'd7);
    idle();
    wait_result();
    total++;
    if ({got, d0, s0, a0} !== {1'b1, 16'h7FFF, 1'b1, 4'd7})
      $display("FAIL sat_pos: got=%b d=%h s=%b a=%0d required got=1 d=7fff s=1 a=7", got, d0, s0, a0);
    else passed++;
    total++;
    if ({d1, s1} !== {16'h7FFF, 1'b1}) $display("FAIL sat_pos_lin: d=%h s=%b required d=7fff s=1", d1, s1);
    else passed++;
    beat(16'h0100, 16'h0200, 1, 1, 4'd8);
    idle();
    wait_result();
    total++;
    if ({got, d0, s0} !== {1'b1, 16'h0200, 1'b0})
      $display("FAIL sat_clear: got=%b d=%h s=%b required got=1 d=0200 s=0", got, d0, s0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd [4];
    logic [3:0]  ra [4];
    int          n = 0;
    @(negedge clk) bus0.out_ready = 1'b0;
    beat(16'h0100, 16'h0100, 1, 0, 4'd0);
    beat(16'h0100, 16'h0100, 0, 1, 4'd0);
    beat(16'h0100, 16'h0300, 1, 0, 4'd1);
    beat(16'h0100, 16'h0300, 0, 1, 4'd1);
    #1;
    total++;
    if ({bus0.in_ready, bus0.out_valid, bus0.out_data, bus0.out_addr} !== {1'b0, 1'b1, 16'h0200, 4'd0})
      $display("FAIL stall_hold: r=%b v=%b d=%h a=%0d required r=0 v=1 d=0200 a=0",
               bus0.in_ready, bus0.out_valid, bus0.out_data, bus0.out_addr);
    else passed++;
    idle();
    repeat (3) @(negedge clk);
    total++;
    if ({bus0.out_valid, bus0.out_data, bus0.out_addr} !== {1'b1, 16'h0200, 4'd0})
      $display("FAIL stall_stable: v=%b d=%h a=%0d required v=1 d=0200 a=0",
               bus0.out_valid, bus0.out_data, bus0.out_addr);
    else passed++;
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus0.out_valid && n < 4) begin
        rd[n] = bus0.out_data;
        ra[n] = bus0.out_addr;
        n++;
      end
      @(negedge clk);
    end
    total++;
    if (n !== 2) $display("FAIL b2b_count: results=%0d required 2", n);
    else passed++;
    total++;
    if (n < 2 || {rd[0], ra[0], rd[1], ra[1]} !== {16'h0200, 4'd0, 16'h0600, 4'd1})
      $display("FAIL b2b_order: d0=%h a0=%0d d1=%h a1=%0d required 0200/0 0600/1",
               rd[0], ra[0], rd[1], ra[1]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) beat(16'h0100, 16'h0100, i == 0, 0, 4'd9);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({bus0.out_valid, bus0.out_data, bus0.out_addr, bus0.out_sat, bus0.seq_err} !== '0)
      $display("FAIL mid_reset: v=%b d=%h a=%h s=%b e=%b required all 0", bus0.out_valid,
               bus0.out_data, bus0.out_addr, bus0.out_sat, bus0.seq_err);
    else passed++;
    @(negedge clk) rst = 1'b0;
    beat(16'h0100, 16'h0100, 1, 1, 4'd5);
    idle();
    wait_result();
    total++;
    if ({got, d0, a0, bus0.seq_err} !== {1'b1, 16'h0100, 4'd5, 1'b0})
      $display("FAIL fresh_neuron: got=%b d=%h a=%0d e=%b required got=1 d=0100 a=5 e=0",
               got, d0, a0, bus0.seq_err);
    else passed++;
    beat(16'h0100, 16'h0100, 0, 1, 4'd6);
    idle();
    wait_result();
    total++;
    if ({got, d0, bus0.seq_err} !== {1'b1, 16'h0100, 1'b1})
      $display("FAIL seq_err_set: got=%b d=%h e=%b required got=1 d=0100 e=1", got, d0, bus0.seq_err);
    else passed++;
    repeat (5) @(negedge clk);
    total++;
    if (bus0.seq_err !== 1'b1) $display("FAIL seq_err_sticky: seq_err=%b required 1", bus0.seq_err);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (bus0.seq_err !== 1'b0) $display("FAIL seq_err_clear: seq_err=%b required 0", bus0.seq_err);
    else passed++;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_beat();
    test_long();
    test_relu();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

`default_nettype wire
